seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_pkg.sv | 7 +
 rtl/seg_tick_gen.sv | 15 +
 rtl/seg_scan_ctrl.sv | 50 +++++
 tb/tb_seg_scan_ctrl.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: shared digit count, nibble/index types and scan-control FSM states
package seg_pkg;
  localparam int NUM_DIGITS = 8;
  typedef logic [3:0] digit_t;
  typedef logic [2:0] sel_t;
  typedef enum logic {IDLE, PEND} state_t;
endpackage

// File: rtl/seg_tick_gen.sv
// seg_tick_gen: prescaler counting 0..CLK_DIV-1, tick high in the terminal-count cycle (clk, rst_n in; tick out)
module seg_tick_gen #(
  parameter int CLK_DIV = 100000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  localparam int W = $clog2(CLK_DIV);
  logic [W-1:0] cnt;
  assign tick = cnt == W'(CLK_DIV - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 8-digit scan controller with shadow/display banks committed on frame wrap (write port, commit, digit_en in; num, sel, blank, frame_start, wr_ready out)
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int CLK_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [2:0] wr_addr,
  input  logic [3:0] wr_data,
  input  logic       commit,
  input  logic [7:0] digit_en,
  output logic [3:0] num,
  output logic [2:0] sel,
  output logic       blank,
  output logic       frame_start
);
  state_t state, state_nxt;
  digit_t [NUM_DIGITS-1:0] shadow_bank, disp_bank;
  logic tick, wrap;
  seg_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (.clk(clk), .rst_n(rst_n), .tick(tick));
  assign wrap  = tick && sel == sel_t'(NUM_DIGITS - 1);
  assign num   = disp_bank[sel];
  assign blank = ~digit_en[sel];
  always_comb begin
    wr_ready  = state == IDLE;
    state_nxt = state == IDLE ? (commit ? PEND : IDLE) : (wrap ? IDLE : PEND);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sel         <= '0;
      frame_start <= 1'b0;
    end else begin
      if (tick) sel <= sel + 1'b1;
      frame_start <= wrap;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      shadow_bank <= '0;
      disp_bank   <= '0;
    end else begin
      if (wr_valid && wr_ready) shadow_bank[wr_addr] <= wr_data;
      if (state == PEND && wrap) disp_bank <= shadow_bank;
    end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: scoreboard bench checking scan timing, shadow/commit behaviour, blanking and reset abort
module tb_seg_scan_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_valid = 1'b0;
  logic       commit = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [3:0] wr_data = '0;
  logic [7:0] digit_en = 8'hFF;
  logic       wr_ready;
  logic [3:0] num;
  logic [2:0] sel;
  logic       blank;
  logic       frame_start;
  int total = 0;
  int bad = 0;
  typedef struct {
    logic [2:0] sel;
    logic [3:0] num;
    logic       blank;
  } exp_t;
  exp_t q[$];
  logic [3:0] exp_shadow[8];
  logic [3:0] exp_disp[8];
  seg_scan_ctrl #(.CLK_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .commit(commit), .digit_en(digit_en),
    .num(num), .sel(sel), .blank(blank), .frame_start(frame_start)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wait_frame(output int n);
    n = 0;
    do begin
      step(1);
      n++;
    end while (!frame_start && n < 100);
    if (!frame_start) chk("frame_timeout", 0, 1);
  endtask
  task automatic push_frame();
    for (int i = 0; i < 8; i++) q.push_back('{3'(i), exp_disp[i], ~digit_en[i]});
  endtask
  task automatic scan_slots();
    exp_t e;
    step(1);
    chk("fs_pulse", frame_start, 0);
    for (int i = 0; i < 8; i++) begin
      if (q.size() == 0) begin
        chk("q_empty", 1, 0);
        return;
      end
      e = q.pop_front();
      chk($sformatf("s%0d_sel", i), sel, e.sel);
      chk($sformatf("s%0d_num", i), num, e.num);
      chk($sformatf("s%0d_blank", i), blank, e.blank);
      if (i < 7) step(4);
    end
  endtask
  task automatic scan_frame();
    int n;
    wait_frame(n);
    scan_slots();
  endtask
  task automatic wr(input logic [2:0] a, input logic [3:0] d, input logic c, input logic acc);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    commit   = c;
    chk("wr_ready", wr_ready, acc);
    if (acc) exp_shadow[a] = d;
    step(1);
    wr_valid = 1'b0;
    commit   = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    for (int i = 0; i < 8; i++) begin
      exp_shadow[i] = '0;
      exp_disp[i]   = '0;
    end
    step(3);
    chk("rst_sel", sel, 0);
    chk("rst_num", num, 0);
    chk("rst_fs", frame_start, 0);
    chk("rst_ready", wr_ready, 1);
    chk("rst_blank", blank, 0);
    rst_n = 1'b1;
    step(3);
    chk("sel_hold", sel, 0);
    step(1);
    chk("sel_step", sel, 1);
    wait_frame(n);
    chk("first_wrap", n, 28);
    wait_frame(n);
    chk("period", n, 32);
    push_frame();
    scan_slots();
    wait_frame(n);
    wr(3'd3, 4'hA, 1'b0, 1'b1);
    commit = 1'b1;
    step(1);
    commit = 1'b0;
    chk("ready_pend", wr_ready, 0);
    step(11);
    chk("hold_sel", sel, 3);
    chk("num_hold", num, 0);
    wr(3'd0, 4'hF, 1'b0, 1'b0);
    exp_disp = exp_shadow;
    push_frame();
    scan_frame();
    chk("ready_idle", wr_ready, 1);
    wait_frame(n);
    wr(3'd5, 4'h5, 1'b1, 1'b1);
    chk("ready_pend2", wr_ready, 0);
    exp_disp = exp_shadow;
    push_frame();
    scan_frame();
    step(2);
    wr(3'd1, 4'h7, 1'b1, 1'b1);
    chk("fs_wrap", frame_start, 1);
    chk("ready_pend3", wr_ready, 0);
    push_frame();
    scan_slots();
    exp_disp = exp_shadow;
    push_frame();
    scan_frame();
    digit_en = 8'hF0;
    push_frame();
    wait_frame(n);
    chk("period_en", n, 3);
    scan_slots();
    digit_en = 8'hFF;
    wait_frame(n);
    wr(3'd2, 4'hC, 1'b1, 1'b1);
    step(5);
    chk("ready_pend4", wr_ready, 0);
    rst_n = 1'b0;
    step(1);
    chk("rst2_ready", wr_ready, 1);
    chk("rst2_sel", sel, 0);
    chk("rst2_num", num, 0);
    chk("rst2_fs", frame_start, 0);
    step(2);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_shadow[i] = '0;
      exp_disp[i]   = '0;
    end
    wait_frame(n);
    chk("rst_wrap", n, 32);
    push_frame();
    scan_slots();
    push_frame();
    scan_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
